// File: rtl/reg_sel_pkg.sv
// ============================================================================
//  reg_sel_pkg
//  Shared state encoding, select-index width and default hold limit for the
//  register-select arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package reg_sel_pkg;

    localparam int IDX_W            = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_sel_arbiter_if.sv
// ============================================================================
//  reg_sel_arbiter_if
//  Request/grant bundle between the requesters and the register-select arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_sel_arbiter_if #(
    parameter int NUM_REQ = 16
);
    import reg_sel_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [IDX_W-1:0]   grantIdx;
    logic               grantValid;
    logic [NUM_REQ-1:0] grant;
    logic               preempt;

    modport master (
        output req,
        input  grantIdx,
        input  grantValid,
        input  grant,
        input  preempt
    );

    modport slave (
        input  req,
        output grantIdx,
        output grantValid,
        output grant,
        output preempt
    );

endinterface

`default_nettype wire

// File: rtl/reg_sel_arbiter_rr_pick.sv
// ============================================================================
//  rr_pick
//  Combinational rotate-priority picker: first asserted request after last_idx.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import reg_sel_pkg::*;
#(
    parameter int NUM_REQ = 16
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   last_idx,
    output logic      [IDX_W-1:0]   winner,
    output logic                    any
);

    // Scan from farthest to nearest so the nearest asserted bit overwrites.
    always_comb begin
        winner = '0;
        any    = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_idx) + k) % NUM_REQ]) begin
                winner = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_sel_arbiter.sv
// ============================================================================
//  reg_sel_arbiter
//  Round-robin owner arbiter for the register-select decoder with bounded hold
//  and a one-cycle dead turnaround between owners.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_sel_arbiter
    import reg_sel_pkg::*;
#(
    parameter int NUM_REQ  = 16,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CNT_W    = 4
) (
    input  wire logic          clock,
    input  wire logic          resetn,
    reg_sel_arbiter_if.slave   bus
);

    // With unlimited hold the counter just parks at all-ones.
    localparam logic [CNT_W-1:0] c_hold_cap = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);

    state_t               r_state;
    logic [IDX_W-1:0]     r_grant_idx;
    logic                 r_grant_valid;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_preempt;
    logic [CNT_W-1:0]     r_hold_cnt;
    logic [IDX_W-1:0]     r_last_idx;

    state_t               w_state_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_valid_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic                 w_preempt_nxt;
    logic [CNT_W-1:0]     w_hold_nxt;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [IDX_W-1:0]     w_winner;
    logic                 w_any;
    logic                 w_own_req;
    logic                 w_other_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (bus.req),
        .last_idx (r_last_idx),
        .winner   (w_winner),
        .any      (w_any)
    );

    assign w_own_req   = |(bus.req & r_grant);
    assign w_other_req = |(bus.req & ~r_grant);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_grant_idx;
        w_valid_nxt   = r_grant_valid;
        w_preempt_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        w_last_nxt    = r_last_idx;
        case (r_state)
            IDLE, TURN: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_winner;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (!w_own_req) begin
                    w_state_nxt = TURN;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = r_grant_idx;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == c_hold_cap) && w_other_req) begin
                    w_state_nxt   = TURN;
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = r_grant_idx;
                    w_preempt_nxt = 1'b1;
                end else if (r_hold_cnt != c_hold_cap) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_nxt[i] = w_valid_nxt && (w_idx_nxt == IDX_W'(i));
        end
    end

    // Last owner resets to the top index so requester 0 ranks first.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_grant       <= '0;
            r_preempt     <= 1'b0;
            r_hold_cnt    <= '0;
            r_last_idx    <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant_idx   <= w_idx_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant       <= w_grant_nxt;
            r_preempt     <= w_preempt_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_last_idx    <= w_last_nxt;
        end
    end

    assign bus.grantIdx   = r_grant_idx;
    assign bus.grantValid = r_grant_valid;
    assign bus.grant      = r_grant;
    assign bus.preempt    = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_reg_sel_arbiter.sv
// ============================================================================
//  tb_reg_sel_arbiter
//  Directed stimulus with a cycle-level reference model for the arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_sel_arbiter;

    localparam int N    = 16;
    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_sel_arbiter_if #(.NUM_REQ(N)) bus ();

    reg_sel_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MAXH),
        .CNT_W    (4)
    ) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Reference model: who owns the path, how long, and who owned it last.
    int m_owner = -1;
    int m_hold  = 0;
    int m_last  = N - 1;
    int m_idx   = 0;
    bit m_pre   = 1'b0;

    function automatic int pick(input logic [N-1:0] rq, input int last);
        for (int k = 1; k <= N; k++) begin
            if (rq[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rn, input logic [N-1:0] rq);
        int w;
        logic [N-1:0] others;
        if (!rn) begin
            m_owner = -1; m_hold = 0; m_last = N - 1; m_idx = 0; m_pre = 1'b0;
            return;
        end
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            others = rq;
            others[m_owner] = 1'b0;
            if (!rq[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end else if (MAXH != 0 && m_hold >= MAXH && others != '0) begin
                m_last = m_owner; m_owner = -1; m_pre = 1'b1;
            end else if (MAXH == 0 || m_hold < MAXH) begin
                m_hold++;
            end
        end else begin
            w = pick(rq, m_last);
            if (w >= 0) begin
                m_owner = w; m_idx = w; m_hold = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled just after each edge.
    initial begin
        logic rn_s;
        logic [N-1:0] rq_s;
        logic [N-1:0] g_exp;
        forever begin
            @(posedge clk);
            rn_s = resetn;
            rq_s = bus.req;
            #1;
            model_step(rn_s, rq_s);
            g_exp = '0;
            if (m_owner >= 0) g_exp[m_idx] = 1'b1;
            chk("model_valid", int'(bus.grantValid), int'(m_owner >= 0));
            chk("model_idx",   int'(bus.grantIdx),   m_idx);
            chk("model_grant", int'(bus.grant),      int'(g_exp));
            chk("model_preempt", int'(bus.preempt),  int'(m_pre));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
    endtask

    initial begin
        int bad;
        bus.req = '0;
        do_reset();
        chk("rst_valid", int'(bus.grantValid), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_idx", int'(bus.grantIdx), 0);
        chk("rst_preempt", int'(bus.preempt), 0);

        // Single requester 0
        resetn = 1'b1; bus.req = 16'h0001;
        cyc(1);
        chk("t1_valid", int'(bus.grantValid), 1);
        chk("t1_idx", int'(bus.grantIdx), 0);
        chk("t1_grant", int'(bus.grant), 16'h0001);
        bus.req = 16'h0000;
        cyc(1);
        chk("t1_turn_valid", int'(bus.grantValid), 0);
        cyc(1);
        chk("t1_idle_valid", int'(bus.grantValid), 0);

        // Requesters 0 and 5
        do_reset();
        resetn = 1'b1; bus.req = 16'h0021;
        cyc(1);
        chk("t2_first", int'(bus.grantIdx), 0);
        bus.req = 16'h0020;
        cyc(1);
        chk("t2_turn_valid", int'(bus.grantValid), 0);
        chk("t2_turn_idx", int'(bus.grantIdx), 0);
        cyc(1);
        chk("t2_second", int'(bus.grantIdx), 5);
        chk("t2_second_grant", int'(bus.grant), 16'h0020);
        bus.req = 16'h0001;
        cyc(1);
        chk("t2_turn2_valid", int'(bus.grantValid), 0);
        cyc(1);
        chk("t2_third", int'(bus.grantIdx), 0);

        // Bounded hold between 1 and 2
        do_reset();
        resetn = 1'b1; bus.req = 16'h0006;
        cyc(1);
        chk("t3_own1", int'(bus.grantIdx), 1);
        cyc(7);
        chk("t3_hold8_valid", int'(bus.grantValid), 1);
        chk("t3_hold8_pre", int'(bus.preempt), 0);
        cyc(1);
        chk("t3_pre1_valid", int'(bus.grantValid), 0);
        chk("t3_pre1", int'(bus.preempt), 1);
        cyc(1);
        chk("t3_own2", int'(bus.grantIdx), 2);
        chk("t3_own2_pre", int'(bus.preempt), 0);
        cyc(7);
        chk("t3_own2_end", int'(bus.grant), 16'h0004);
        cyc(1);
        chk("t3_pre2", int'(bus.preempt), 1);
        cyc(1);
        chk("t3_own1_again", int'(bus.grantIdx), 1);

        // Sole requester 15
        do_reset();
        resetn = 1'b1; bus.req = 16'h8000;
        cyc(1);
        chk("t4_own15", int'(bus.grantIdx), 15);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (!bus.grantValid || bus.preempt || bus.grantIdx != 4'd15) bad++;
        end
        chk("t4_sole_steady", bad, 0);

        // Wrap-around from 15
        bus.req = 16'h8003;
        cyc(1);
        chk("t5_release", int'(bus.grantValid), 0);
        cyc(2);
        chk("t5_wrap0", int'(bus.grantIdx), 0);
        bus.req = 16'h8002;
        cyc(2);
        chk("t5_next1", int'(bus.grantIdx), 1);

        // Reset during a grant
        do_reset();
        resetn = 1'b1; bus.req = 16'h0080;
        cyc(1);
        chk("t6_own7", int'(bus.grantIdx), 7);
        resetn = 1'b0;
        cyc(1);
        chk("t6_rst_valid", int'(bus.grantValid), 0);
        chk("t6_rst_grant", int'(bus.grant), 0);
        chk("t6_rst_idx", int'(bus.grantIdx), 0);
        chk("t6_rst_pre", int'(bus.preempt), 0);
        resetn = 1'b1; bus.req = 16'h0081;
        cyc(1);
        chk("t6_after_rst", int'(bus.grantIdx), 0);
        chk("t6_after_rst_grant", int'(bus.grant), 16'h0001);

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_sel_arbiter.md
Name: reg_sel_arbiter

Overview:
Round-robin arbiter that shares the 16-entry register-select path between up to 16 requesters (control unit, I/O port, debug/loader, etc.). It grants one requester at a time and drives a registered 4-bit select index plus a valid strobe into the 4-to-16 register-select decoder. Grants can be held for several cycles, with bounded preemption for fairness. A one-cycle dead turnaround is inserted between owners to avoid bus contention.

Parameters:
NUM_REQ, 16, number of requesters; legal 2..16; index i maps to decoder select value i.
MAX_HOLD, 8, maximum consecutive granted cycles before forced release when another request is pending; 0 = unlimited hold.
CNT_W, 4, width of hold counter; must hold MAX_HOLD.

Ports:
clock  in  1  rising-edge clock.
resetn  in  1  synchronous active-low reset.
req  in  NUM_REQ  per-requester request level; bit i asserted = requester i wants the register-select path.
grantIdx  out  4  registered index of the current or last owner; feeds decoder input.
grantValid  out  1  high when grantIdx is a live grant; gates the decoded enables.
grant  out  NUM_REQ  one-hot grant, equal to (grantValid ? 1<<grantIdx : 0).
preempt  out  1  one-cycle pulse on the cycle a grant is force-released by MAX_HOLD.

Behaviour:
- All outputs registered. Reset is sampled only at rising clock edge with resetn=0: state=IDLE, grantValid=0, grant=0, grantIdx=0, preempt=0, holdCnt=0, lastIdx=NUM_REQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-grant: the grant drops at that edge; there is no turnaround cycle and no preempt pulse.
- Pick function (combinational): scan req starting at (lastIdx+1) mod NUM_REQ, ascending and wrapping at NUM_REQ-1; the first asserted bit wins. No request means no winner.
- States:
  - IDLE: grantValid=0. If a winner exists, then at the next edge grantIdx=winner, grantValid=1, holdCnt=1, go to GRANT. Latency from req sampled high to grantValid high is 1 cycle.
  - GRANT: grantValid=1, grantIdx stable.
    - If req[grantIdx]=0 at an edge: go to TURN, grantValid=0, lastIdx=grantIdx.
    - Else if MAX_HOLD!=0, holdCnt==MAX_HOLD, and any other req bit is set: go to TURN, grantValid=0, lastIdx=grantIdx, preempt=1 for that cycle.
    - Else: stay; holdCnt increments, saturating at MAX_HOLD. A sole requester keeps the grant indefinitely.
  - TURN: grantValid=0 for exactly one cycle; grantIdx retains the old value. It applies the same pick as IDLE with the updated lastIdx. With a winner, go to GRANT (holdCnt=1); otherwise go to IDLE.
- Minimum gap between two different owners: 1 cycle. A released owner that re-requests immediately is ranked last and can win only if no other request is pending.
- Simultaneous release and new requests in the same cycle: the release is honoured; new requests are arbitrated in TURN.
- req bits that drop while not granted are simply not picked; there is no latching of requests.
- grant and grantValid never change except at clock edges. grant is all-zero whenever grantValid=0.

Decomposition:
- Shared package/include reg_sel_pkg: state encoding constants (IDLE=2'd0, GRANT=2'd1, TURN=2'd2), IDX_W=4, and a default MAX_HOLD.
- One sub-module, rr_pick: purely combinational rotate-priority picker. Inputs: req and lastIdx. Outputs: winner index and any-valid.
- The FSM, hold counter and output registers stay in reg_sel_arbiter.

Test Plan:
- Reset then req=16'h0001 held: at cycle 1 after reset release, grantValid=1, grantIdx=0, grant=16'h0001. Drop req: TURN for 1 cycle, then IDLE, grantValid=0.
- req=16'h0021 (requesters 0 and 5) from reset: 0 is granted first. On release of 0, TURN for 1 cycle, then grantIdx=5. On release of 5 with 0 still requesting, grantIdx=0 again after TURN.
- MAX_HOLD=8, req=16'h0006 held constantly: requester 1 is granted for exactly 8 cycles, preempt pulses once, TURN, requester 2 is granted for 8 cycles. The pattern alternates 1,2,1,2.
- Sole requester req=16'h8000 held for 50 cycles: grantIdx=15 continuously, with no preempt and no TURN.
- Wrap-around: after an owner at index 15 releases with req=16'h8003, the next grant is index 0, then index 1.
- resetn low during GRANT of index 7: at the next edge grantValid=0, grant=0, grantIdx=0. After reset release with req=16'h0081, index 0 is granted first.
